// File: rtl/ycr_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ycr_dmem_arbiter_if
// One DMEM req/req_ack/resp port bundle, shared by requesters and targets.
//
// Signals:
//   req      request valid              (master -> slave)
//   cmd      0 = read, 1 = write        (master -> slave)
//   width    byte / half / word         (master -> slave)
//   addr     address                    (master -> slave)
//   wdata    write data                 (master -> slave)
//   req_ack  address accepted           (slave  -> master)
//   rdata    read data                  (slave  -> master)
//   resp     IDLE=0, RDY_OK=1, RDY_ER=2 (slave  -> master)
//
// Modports:
//   master : the side that issues requests (a requester, or the arbiter
//            towards the target)
//   slave  : the side that accepts requests (a target, or the arbiter
//            towards each requester)
// ---------------------------------------------------------------------------
`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

interface ycr_dmem_arbiter_if;
    logic                        req;
    logic                        cmd;
    logic [1:0]                  width;
    logic [`YCR_DMEM_AWIDTH-1:0] addr;
    logic [`YCR_DMEM_DWIDTH-1:0] wdata;
    logic                        req_ack;
    logic [`YCR_DMEM_DWIDTH-1:0] rdata;
    logic [1:0]                  resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );
endinterface

// File: rtl/ycr_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// ycr_dmem_arbiter
// Two-requester arbiter in front of one data-memory target port. m0 is the
// core LSU path, m1 the debug/DMA path. One transaction is outstanding at a
// time; the next address phase may overlap the current data phase when the
// target answers RDY_OK in the same cycle it accepts the new address.
//
// Parameters:
//   ARB_RR          1 = round-robin on simultaneous requests, 0 = m0 wins
//   TIMEOUT_CYCLES  data-phase watchdog limit (8-bit), optional feature only
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   m0     requester port 0 (slave modport)
//   m1     requester port 1 (slave modport)
//   s      target port (master modport)
//
// Optional feature macro: YCR_DMEM_ARB_TIMEOUT_EN
//   When defined, a data phase that sees no target response for
//   TIMEOUT_CYCLES cycles is terminated with RDY_ER to the owner.
// ---------------------------------------------------------------------------
`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

module ycr_dmem_arbiter #(
    parameter bit          ARB_RR         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ycr_dmem_arbiter_if.slave     m0,
    ycr_dmem_arbiter_if.slave     m1,
    ycr_dmem_arbiter_if.master    s
);

    localparam logic [1:0] RESP_IDLE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ER   = 2'd2;

    // The watchdog counter is 8 bits wide; a limit of 0 would fire on entry.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("ycr_dmem_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   rr_last_q, rr_last_d;
    logic   lock_vld_q, lock_vld_d;
    logic   lock_id_q, lock_id_d;

    logic   win;
    logic   grant;
    logic   s_req_c;
    logic   handshake;
    logic   timeout_hit;
    logic [1:0] resp_fwd;

`ifdef YCR_DMEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

    logic [7:0] to_cnt_q, to_cnt_d;

    // Fires only on a cycle where the target is still silent, so a response
    // arriving exactly at the limit is forwarded normally.
    assign timeout_hit = (state_q == ST_DATA) && (s.resp == RESP_IDLE) &&
                         (to_cnt_q == TIMEOUT_LIMIT);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (handshake || timeout_hit) begin
            to_cnt_d = 8'd0;
        end else if ((state_q == ST_DATA) && (s.resp == RESP_IDLE)) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Grant, window and next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;

        // A new address may be taken while idle, or while the current data
        // phase completes successfully this very cycle.
        win = (state_q == ST_ADDR) || (s.resp == RESP_OK);

        if (lock_vld_q) begin
            grant = lock_id_q;
        end else if (m0.req && m1.req) begin
            grant = ARB_RR ? ~rr_last_q : 1'b0;
        end else begin
            grant = m1.req;
        end

        s_req_c   = win && (grant ? m1.req : m0.req);
        handshake = s_req_c && s.req_ack;

        // Keep the grant pinned to a presented-but-unaccepted request so the
        // target sees a stable address.
        if (handshake) begin
            lock_vld_d = 1'b0;
        end else if (s_req_c) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant;
        end

        if (handshake) begin
            state_d   = ST_DATA;
            owner_d   = grant;
            rr_last_d = grant;
        end else if ((state_q == ST_DATA) &&
                     ((s.resp != RESP_IDLE) || timeout_hit)) begin
            state_d = ST_ADDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ADDR;
            owner_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end

    // Target side: mux of the granted requester
    assign s.req   = s_req_c;
    assign s.cmd   = grant ? m1.cmd   : m0.cmd;
    assign s.width = grant ? m1.width : m0.width;
    assign s.addr  = grant ? m1.addr  : m0.addr;
    assign s.wdata = grant ? m1.wdata : m0.wdata;

    // Requester side: ack to the granted one, response to the owner only
    assign m0.req_ack = win && s.req_ack && !grant;
    assign m1.req_ack = win && s.req_ack &&  grant;

    assign resp_fwd = timeout_hit ? RESP_ER : s.resp;

    assign m0.resp  = ((state_q == ST_DATA) && !owner_q) ? resp_fwd : RESP_IDLE;
    assign m1.resp  = ((state_q == ST_DATA) &&  owner_q) ? resp_fwd : RESP_IDLE;
    assign m0.rdata = ((state_q == ST_DATA) && !owner_q) ? s.rdata : '0;
    assign m1.rdata = ((state_q == ST_DATA) &&  owner_q) ? s.rdata : '0;

endmodule

// File: tb/tb_ycr_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ycr_dmem_arbiter
// Directed vector table, hand-written corner sequences (timeout, reset in
// the middle of a transaction) and a randomized run against a transaction-
// level reference model of the arbiter.
// ---------------------------------------------------------------------------
`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

module tb_ycr_dmem_arbiter;

    localparam logic [1:0]  R_IDLE = 2'd0;
    localparam logic [1:0]  R_OK   = 2'd1;
    localparam logic [1:0]  R_ER   = 2'd2;
    localparam int          TO     = 8;
    localparam logic [31:0] A0     = 32'h0001_0004;
    localparam logic [31:0] A1     = 32'h0002_0008;
    localparam logic [31:0] D0     = 32'h1111_2222;
    localparam logic [31:0] D1     = 32'h3333_4444;
    localparam logic [31:0] RD     = 32'hDEAD_BEEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ycr_dmem_arbiter_if m0_if();
    ycr_dmem_arbiter_if m1_if();
    ycr_dmem_arbiter_if s_if();

    ycr_dmem_arbiter #(.ARB_RR(1'b1), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- stimulus state ----------------
    logic        r_m[2];
    logic        cmd_m[2];
    logic [1:0]  w_m[2];
    logic [31:0] a_m[2];
    logic [31:0] d_m[2];
    logic        s_ack_m;
    logic [1:0]  s_resp_m;
    logic [31:0] s_rdata_m;

    task automatic apply();
        m0_if.req = r_m[0]; m0_if.cmd = cmd_m[0]; m0_if.width = w_m[0];
        m0_if.addr = a_m[0]; m0_if.wdata = d_m[0];
        m1_if.req = r_m[1]; m1_if.cmd = cmd_m[1]; m1_if.width = w_m[1];
        m1_if.addr = a_m[1]; m1_if.wdata = d_m[1];
        s_if.req_ack = s_ack_m;
        s_if.resp    = s_resp_m;
        s_if.rdata   = s_rdata_m;
    endtask

    task automatic set_std(input logic r0, input logic r1, input logic ack, input logic [1:0] resp);
        r_m[0] = r0; cmd_m[0] = 1'b1; w_m[0] = 2'd2; a_m[0] = A0; d_m[0] = D0;
        r_m[1] = r1; cmd_m[1] = 1'b0; w_m[1] = 2'd2; a_m[1] = A1; d_m[1] = D1;
        s_ack_m = ack; s_resp_m = resp; s_rdata_m = RD;
        apply();
    endtask

    // ---------------- reference model ----------------
    // Tracks "is a transaction in flight, who owns it, who won last, who is
    // waiting with an unaccepted address" and derives the outputs from the
    // arbitration rules directly.
    bit         m_busy;
    int         m_owner, m_last, m_lock, m_cnt;
    bit         m_to;
    int         e_g;
    bit         e_sreq;
    bit         e_ack[2];
    logic [1:0] e_resp[2];
    bit         e_rd[2];

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_lock = -1; m_cnt = 0;
    endtask

    task automatic model_eval();
        bit win;
`ifdef YCR_DMEM_ARB_TIMEOUT_EN
        m_to = m_busy && (s_resp_m == R_IDLE) && (m_cnt == TO);
`else
        m_to = 0;
`endif
        win = !m_busy || (s_resp_m == R_OK);
        if (m_lock >= 0)             e_g = m_lock;
        else if (r_m[0] && r_m[1])   e_g = (m_last == 0) ? 1 : 0;
        else                         e_g = r_m[1] ? 1 : 0;
        e_sreq = win && r_m[e_g];
        for (int i = 0; i < 2; i++) begin
            e_ack[i]  = win && s_ack_m && (e_g == i);
            e_resp[i] = R_IDLE;
            e_rd[i]   = 0;
        end
        if (m_busy) begin
            e_resp[m_owner] = m_to ? R_ER : s_resp_m;
            e_rd[m_owner]   = 1;
        end
    endtask

    task automatic model_step();
        bit hs;
        hs = e_sreq && s_ack_m;
        if (hs)          m_lock = -1;
        else if (e_sreq) m_lock = e_g;
        if (hs) begin
            m_owner = e_g; m_last = e_g; m_cnt = 0;
        end else if (m_busy && s_resp_m == R_IDLE) begin
            m_cnt = m_to ? 0 : m_cnt + 1;
        end
        m_busy = hs || (m_busy && s_resp_m == R_IDLE && !m_to);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       r0, r1, ack;
        bit [1:0] resp;
        bit       e_sreq, e_g, e_ack0, e_ack1;
        bit [1:0] e_resp0, e_resp1;
        bit       e_rd0, e_rd1;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int stall;
        int cyc;

        //          r0 r1 ak rs | sq g a0 a1 p0 p1 d0 d1
        tbl[0]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};  // idle
        tbl[1]  = '{1, 0, 1, 0,   1, 0, 1, 0, 0, 0, 0, 0};  // m0 read accepted
        tbl[2]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0};  // waiting, owner m0
        tbl[3]  = '{0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1, 0};  // RDY_OK to m0
        tbl[4]  = '{1, 1, 1, 0,   1, 1, 0, 1, 0, 0, 0, 0};  // both: m1 (m0 won last)
        tbl[5]  = '{1, 1, 1, 1,   1, 0, 1, 0, 0, 1, 0, 1};  // b2b: m0 in, OK to m1
        tbl[6]  = '{1, 1, 1, 1,   1, 1, 0, 1, 1, 0, 1, 0};  // b2b: m1 in, OK to m0
        tbl[7]  = '{0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0, 1};  // OK to m1, back to idle
        tbl[8]  = '{0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0};  // m1 stalled -> lock
        tbl[9]  = '{1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0};  // m0 arrives, lock holds
        tbl[10] = '{1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 1, 0,   1, 1, 0, 1, 0, 0, 0, 0};  // m1 accepted first
        tbl[12] = '{1, 0, 1, 2,   0, 0, 0, 0, 0, 2, 0, 1};  // RDY_ER: no new accept
        tbl[13] = '{1, 0, 1, 0,   1, 0, 1, 0, 0, 0, 0, 0};  // m0 accepted next cycle
        tbl[14] = '{0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1, 0};  // OK to m0
        tbl[15] = '{0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0};  // stray OK in ADDR ignored

        // ---- reset and idle ----
        set_std(0, 0, 0, R_IDLE);
        repeat (3) @(posedge clk);
        #2;
        chk("rst s_req", s_if.req, 0);
        chk("rst m0_req_ack", m0_if.req_ack, 0);
        chk("rst m1_req_ack", m1_if.req_ack, 0);
        chk("rst m0_resp", m0_if.resp, R_IDLE);
        chk("rst m1_resp", m1_if.resp, R_IDLE);
        chk("rst m0_rdata", m0_if.rdata, 0);
        chk("rst m1_rdata", m1_if.rdata, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #5;
            chk($sformatf("idle%0d s_req", c), s_if.req, 0);
            chk($sformatf("idle%0d acks", c), {m0_if.req_ack, m1_if.req_ack}, 0);
            chk($sformatf("idle%0d resps", c), {m0_if.resp, m1_if.resp}, 0);
        end

        // ---- vector table ----
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            set_std(tbl[i].r0, tbl[i].r1, tbl[i].ack, tbl[i].resp);
            #4;
            chk($sformatf("vec%0d s_req", i), s_if.req, tbl[i].e_sreq);
            chk($sformatf("vec%0d m0_req_ack", i), m0_if.req_ack, tbl[i].e_ack0);
            chk($sformatf("vec%0d m1_req_ack", i), m1_if.req_ack, tbl[i].e_ack1);
            chk($sformatf("vec%0d m0_resp", i), m0_if.resp, tbl[i].e_resp0);
            chk($sformatf("vec%0d m1_resp", i), m1_if.resp, tbl[i].e_resp1);
            chk($sformatf("vec%0d m0_rdata", i), m0_if.rdata, tbl[i].e_rd0 ? RD : 32'h0);
            chk($sformatf("vec%0d m1_rdata", i), m1_if.rdata, tbl[i].e_rd1 ? RD : 32'h0);
            if (tbl[i].e_sreq) begin
                chk($sformatf("vec%0d s_addr", i), s_if.addr, tbl[i].e_g ? A1 : A0);
                chk($sformatf("vec%0d s_cmd", i), s_if.cmd, tbl[i].e_g ? 1'b0 : 1'b1);
            end
            $display("vec%0d r0=%0d r1=%0d ack=%0d resp=%0d -> s_req=%0d addr=%h",
                     i, tbl[i].r0, tbl[i].r1, tbl[i].ack, tbl[i].resp, s_if.req, s_if.addr);
        end

`ifdef YCR_DMEM_ARB_TIMEOUT_EN
        // ---- watchdog: target accepts but never answers ----
        @(posedge clk); #1; set_std(1, 0, 1, R_IDLE);
        for (int k = 0; k <= TO; k++) begin
            @(posedge clk); #1; set_std(0, 0, 0, R_IDLE);
            #4;
            chk($sformatf("to%0d m0_resp", k), m0_if.resp, (k == TO) ? R_ER : R_IDLE);
        end
        @(posedge clk); #1; set_std(0, 0, 0, R_OK);
        #4;
        chk("to late m0_resp", m0_if.resp, R_IDLE);
        chk("to late m1_resp", m1_if.resp, R_IDLE);
        $display("timeout sequence done");
`endif

        // ---- reset in the middle of a data phase ----
        @(posedge clk); #1; set_std(1, 0, 1, R_IDLE);
        @(posedge clk); #1; set_std(0, 0, 0, R_OK);
        #1;
        chk("mid pre-rst m0_resp", m0_if.resp, R_OK);
        #1; rst_n = 1'b0;
        #1;
        chk("mid rst m0_resp", m0_if.resp, R_IDLE);
        chk("mid rst m0_rdata", m0_if.rdata, 0);
        set_std(1, 1, 0, R_IDLE);
        #1;
        chk("mid rst s_req", s_if.req, 1);
        chk("mid rst s_addr (m0 first)", s_if.addr, A0);
        set_std(0, 0, 0, R_IDLE);
        #1; rst_n = 1'b1;
        $display("mid-transaction reset sequence done");

        // ---- randomized run against the model ----
        model_reset();
        stall = 0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            bit acc[2];
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!r_m[i] || acc[i]) begin
                    r_m[i]   = ($urandom_range(0, 2) != 0);
                    cmd_m[i] = 1'($urandom_range(0, 1));
                    w_m[i]   = 2'($urandom_range(0, 2));
                    a_m[i]   = $urandom;
                    d_m[i]   = $urandom;
                end
            end
            s_ack_m   = ($urandom_range(0, 3) != 0);
            s_rdata_m = $urandom;
            if (stall == 0 && $urandom_range(0, 199) == 0) stall = 12;
            if (stall > 0) begin
                s_resp_m = R_IDLE;
                stall--;
            end else begin
                int p;
                p = $urandom_range(0, 9);
                s_resp_m = (p < 4) ? R_IDLE : (p < 8) ? R_OK : R_ER;
            end
            apply();
            model_eval();
            #4;
            chk($sformatf("c%0d s_req", cyc), s_if.req, e_sreq);
            chk($sformatf("c%0d m0_req_ack", cyc), m0_if.req_ack, e_ack[0]);
            chk($sformatf("c%0d m1_req_ack", cyc), m1_if.req_ack, e_ack[1]);
            chk($sformatf("c%0d m0_resp", cyc), m0_if.resp, e_resp[0]);
            chk($sformatf("c%0d m1_resp", cyc), m1_if.resp, e_resp[1]);
            chk($sformatf("c%0d m0_rdata", cyc), m0_if.rdata, e_rd[0] ? s_rdata_m : 32'h0);
            chk($sformatf("c%0d m1_rdata", cyc), m1_if.rdata, e_rd[1] ? s_rdata_m : 32'h0);
            if (e_sreq) begin
                chk($sformatf("c%0d s_addr", cyc), s_if.addr, a_m[e_g]);
                chk($sformatf("c%0d s_wdata", cyc), s_if.wdata, d_m[e_g]);
                chk($sformatf("c%0d s_cmd", cyc), s_if.cmd, cmd_m[e_g]);
                chk($sformatf("c%0d s_width", cyc), s_if.width, w_m[e_g]);
            end
            if (e_sreq && s_ack_m)
                $display("c%0d accept m%0d addr=%h cmd=%0d", cyc, e_g, a_m[e_g], cmd_m[e_g]);
            for (int i = 0; i < 2; i++) acc[i] = r_m[i] && e_ack[i];
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
